buffer_v2: RTL and testbench
============================

Name: buffer_v2

Overview:
- Second-generation parametrised storage buffer. Single clock domain, selectable FIFO or LIFO pop order.
- Adds over the previous generation: simultaneous push+pop, an occupancy count, programmable almost-full/almost-empty flags, a pop-valid strobe, and per-cause error reporting.
- Sits between a producer and a consumer that use push/pop strobes with enables.

Parameters:
- DATA_WIDTH, 8, data word width in bits (>=1).
- DEPTH, 8, number of entries (>=2; need not be a power of two).
- POP_ORDER, "FIFO", "FIFO" or "LIFO". Any other value causes $fatal at elaboration.
- AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- push_en  in  1  push enable
- push  in  1  push request
- pop_en  in  1  pop enable
- pop  in  1  pop request
- data_in  in  DATA_WIDTH  write data, sampled on an accepted push
- data_out  out  DATA_WIDTH  registered read data
- data_valid  out  1  one-cycle pulse: data_out was updated by an accepted pop
- count  out  $clog2(DEPTH+1)  current number of entries
- is_empty  out  1  count == 0
- is_full  out  1  count == DEPTH
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- err  out  3  registered one-cycle error causes: [0] disabled request, [1] overflow, [2] underflow
- err_clr  in  1  clears sticky errors (present only with BUFFER_V2_STICKY_ERR_EN)
- err_sticky  out  3  sticky OR of err (present only with BUFFER_V2_STICKY_ERR_EN)

Behaviour:
- Reset: single clock, clk. Reset is asynchronous, active-low on rst_n. While rst_n=0, all state clears: pointers and count = 0, storage = 0, data_out = 0, data_valid = 0, err = 0, err_sticky = 0. Consequently is_empty=1, is_full=0, almost_empty=1, and almost_full=(AF_LEVEL==0).
- Reset mid-operation: all contents are discarded immediately. No pop completes on that edge.
- Acceptance terms:
  - push_ok = push & push_en & (~is_full | pop_ok)
  - pop_ok = pop & pop_en & ~is_empty
- Error causes, registered on the next edge:
  - disabled: (push & ~push_en) | (pop & ~pop_en)
  - overflow: push & push_en & is_full & ~pop_ok
  - underflow: pop & pop_en & is_empty
- Error isolation: an erroring request is dropped. The other request in the same cycle is still honoured if it is legal.
- Pop latency: 1 cycle. On the edge where pop_ok is true, data_out takes the selected entry and data_valid=1 for the following cycle. Otherwise data_out holds and data_valid=0.
- Count update: +1 on push only, -1 on pop only, unchanged on push+pop. Flags are derived combinationally from the count register.
- FIFO mode:
  - Write at wr_ptr, read at rd_ptr.
  - Each pointer increments on its accepted operation and wraps from DEPTH-1 to 0 (explicit compare, not modulo power of two).
  - Push+pop when full: both are accepted. The read returns the oldest entry, and the write uses the slot freed on the same edge.
  - Push+pop when empty: underflow is flagged and the push is accepted.
- LIFO mode:
  - A single top pointer tp equals count. Push writes mem[tp] and increments tp. Pop reads mem[tp-1] and decrements tp.
  - Push+pop with count>0 is a replace: data_out <= mem[tp-1], mem[tp-1] <= data_in, tp is unchanged. This is legal even when full.
  - Push+pop when empty: underflow is flagged and the push is accepted.

Optional Feature:
- Macro: BUFFER_V2_STICKY_ERR_EN.
- Defined: err_clr and err_sticky exist. err_sticky <= (err_sticky | err) & ~{3{err_clr}}. If err_clr coincides with a new error, the clear wins for the old bits and the new err bits are ORed in on the next cycle.
- Undefined: both ports are absent. Only the pulsed err output exists.

Decomposition:
- buffer_v2_pkg contains:
  - pop_order_e enum {FIFO, LIFO}
  - err_idx constants ERR_DIS=0, ERR_OVF=1, ERR_UNF=2
  - function clog2_min1(n) for pointer width (minimum 1)
- One sub-module, buffer_v2_ptr: mode-parameterised pointer/count engine. It outputs wr_addr, rd_addr and count. buffer_v2 holds the storage, the data_out register and the error logic.

Test Plan (DATA_WIDTH=8, DEPTH=8, both modes unless noted):
- Reset, then push 0x01..0x08 -> count=8, is_full=1, almost_full from count=7. A 9th push gives err[1]=1 for one cycle and count stays 8.
- FIFO: after the fill, pop x3 -> data_out 0x01, 0x02, 0x03, each with data_valid one cycle after the pop and count=5. LIFO gives 0x08, 0x07, 0x06.
- FIFO full: push 0x09 + pop together -> data_out=0x01, count=8. Later drain: 0x02..0x08, then 0x09, which exercises pointer wrap.
- LIFO with count=3 (top=0x03): push 0x0A + pop -> data_out=0x03, count=3. The next pop returns 0x0A.
- Empty buffer: pop -> err[2]=1. push=1 with push_en=0 -> err[0]=1. With sticky enabled, err_sticky=3'b101 until err_clr.
- Assert rst_n=0 mid-fill at count=4 -> outputs reset immediately. After release, pop -> err[2]=1 and data_out stays 0.

Source files
------------

// File: rtl/buffer_v2_pkg.sv
// Shared types and helpers for buffer_v2: pop-order selector, err bit indices,
// and the pointer-width function.
package buffer_v2_pkg;

  typedef enum logic {
    FIFO,
    LIFO
  } pop_order_e;

  localparam int ERR_DIS = 0;
  localparam int ERR_OVF = 1;
  localparam int ERR_UNF = 2;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/buffer_v2_ptr.sv
// Pointer/count engine for buffer_v2. FIFO mode keeps wrapping write and read
// pointers; LIFO mode derives both addresses from the count, which is the stack top.
module buffer_v2_ptr
  import buffer_v2_pkg::*;
#(
  parameter int         DEPTH = 8,
  parameter pop_order_e MODE  = FIFO,
  localparam int        PW    = clog2_min1(DEPTH),
  localparam int        CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_ok,
  input  logic          pop_ok,
  output logic [PW-1:0] wr_addr,
  output logic [PW-1:0] rd_addr,
  output logic [CW-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (push_ok && !pop_ok) begin
      count <= count + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count <= count - CW'(1);
    end
  end

  if (MODE == FIFO) begin : g_fifo
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // DEPTH need not be a power of two, so wrap on an explicit compare
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
        if (pop_ok)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
    end

    always_comb begin
      wr_addr = wr_ptr;
      rd_addr = rd_ptr;
    end
  end else begin : g_lifo
    // push+pop together is a replace of the top entry, so both address tp-1
    always_comb begin
      rd_addr = PW'(count - CW'(1));
      wr_addr = pop_ok ? PW'(count - CW'(1)) : PW'(count);
    end
  end

endmodule

// File: rtl/buffer_v2.sv
// Parametrised FIFO/LIFO buffer with occupancy flags, pop-valid strobe and
// per-cause error pulses. Sticky error capture is enabled by BUFFER_V2_STICKY_ERR_EN.
module buffer_v2
  import buffer_v2_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter     POP_ORDER  = "FIFO",
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_en,
  input  logic                         push,
  input  logic                         pop_en,
  input  logic                         pop,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         data_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         is_empty,
  output logic                         is_full,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [2:0]                   err
`ifdef BUFFER_V2_STICKY_ERR_EN
  ,
  input  logic                         err_clr,
  output logic [2:0]                   err_sticky
`endif
);

  localparam int         PW   = clog2_min1(DEPTH);
  localparam int         CW   = $clog2(DEPTH + 1);
  localparam pop_order_e MODE = (POP_ORDER == "LIFO") ? LIFO : FIFO;

  if ((POP_ORDER != "FIFO") && (POP_ORDER != "LIFO")) begin : g_bad_pop_order
    $fatal(1, "buffer_v2: POP_ORDER must be \"FIFO\" or \"LIFO\"");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_addr;
  logic [PW-1:0]         rd_addr;
  logic                  push_ok;
  logic                  pop_ok;
  logic [2:0]            err_d;

  buffer_v2_ptr #(
    .DEPTH (DEPTH),
    .MODE  (MODE)
  ) u_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_ok (push_ok),
    .pop_ok  (pop_ok),
    .wr_addr (wr_addr),
    .rd_addr (rd_addr),
    .count   (count)
  );

  always_comb begin
    is_empty     = (count == '0);
    is_full      = (count == CW'(DEPTH));
    almost_full  = (count >= CW'(AF_LEVEL));
    almost_empty = (count <= CW'(AE_LEVEL));
  end

  always_comb begin
    pop_ok           = pop && pop_en && !is_empty;
    push_ok          = push && push_en && (!is_full || pop_ok);
    err_d            = '0;
    err_d[ERR_DIS]   = (push && !push_en) || (pop && !pop_en);
    err_d[ERR_OVF]   = push && push_en && is_full && !pop_ok;
    err_d[ERR_UNF]   = pop && pop_en && is_empty;
  end

  // A same-edge write to the slot being read is safe: the read sees the old value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_addr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      err        <= '0;
    end else begin
      data_valid <= pop_ok;
      err        <= err_d;
      if (pop_ok) data_out <= mem[rd_addr];
    end
  end

`ifdef BUFFER_V2_STICKY_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= '0;
    end else begin
      err_sticky <= (err_sticky | err) & ~{3{err_clr}};
    end
  end
`endif

endmodule

// File: tb/tb_buffer_v2.sv
// Bench for buffer_v2: FIFO and LIFO instances share stimulus and are checked
// every cycle against queue-based reference models, plus directed literal checks.
module tb_buffer_v2;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push_en = 1'b0, push = 1'b0, pop_en = 1'b0, pop = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] data_in = '0;

  logic [7:0] dout_f, dout_l;
  logic       vld_f, vld_l, emp_f, emp_l, full_f, full_l, af_f, af_l, ae_f, ae_l;
  logic [3:0] cnt_f, cnt_l;
  logic [2:0] err_f, err_l;
`ifdef BUFFER_V2_STICKY_ERR_EN
  logic [2:0] stk_f, stk_l;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  buffer_v2 #(.DATA_WIDTH(8), .DEPTH(DEPTH), .POP_ORDER("FIFO")) dut_f (
    .clk(clk), .rst_n(rst_n), .push_en(push_en), .push(push), .pop_en(pop_en), .pop(pop),
    .data_in(data_in), .data_out(dout_f), .data_valid(vld_f), .count(cnt_f),
    .is_empty(emp_f), .is_full(full_f), .almost_full(af_f), .almost_empty(ae_f), .err(err_f)
`ifdef BUFFER_V2_STICKY_ERR_EN
    , .err_clr(err_clr), .err_sticky(stk_f)
`endif
  );

  buffer_v2 #(.DATA_WIDTH(8), .DEPTH(DEPTH), .POP_ORDER("LIFO")) dut_l (
    .clk(clk), .rst_n(rst_n), .push_en(push_en), .push(push), .pop_en(pop_en), .pop(pop),
    .data_in(data_in), .data_out(dout_l), .data_valid(vld_l), .count(cnt_l),
    .is_empty(emp_l), .is_full(full_l), .almost_full(af_l), .almost_empty(ae_l), .err(err_l)
`ifdef BUFFER_V2_STICKY_ERR_EN
    , .err_clr(err_clr), .err_sticky(stk_l)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as queues, outputs as the registered results
  logic [7:0] qf[$];
  logic [7:0] ql[$];
  logic [7:0] m_dout_f = '0, m_dout_l = '0;
  logic       m_vld = 1'b0;
  logic [2:0] m_err = '0, m_stk = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qf.delete();
      ql.delete();
      m_dout_f = '0;
      m_dout_l = '0;
      m_vld    = 1'b0;
      m_err    = '0;
      m_stk    = '0;
    end else begin
      int n;
      bit pok, puok;
      n    = qf.size();
      pok  = pop && pop_en && (n != 0);
      puok = push && push_en && ((n != DEPTH) || pok);
      m_stk = (m_stk | m_err) & ~{3{err_clr}};
      m_err = {pop && pop_en && (n == 0),
               push && push_en && (n == DEPTH) && !pok,
               (push && !push_en) || (pop && !pop_en)};
      m_vld = pok;
      if (pok) m_dout_f = qf.pop_front();
      if (puok) qf.push_back(data_in);
      if (pok && puok) begin
        m_dout_l = ql[ql.size()-1];
        ql[ql.size()-1] = data_in;
      end else if (pok) begin
        m_dout_l = ql.pop_back();
      end else if (puok) begin
        ql.push_back(data_in);
      end
    end
  end

  always @(negedge clk) begin
    chk("dout_f", dout_f, m_dout_f);
    chk("dout_l", dout_l, m_dout_l);
    chk("vld_f", vld_f, m_vld);
    chk("vld_l", vld_l, m_vld);
    chk("cnt_f", cnt_f, qf.size());
    chk("cnt_l", cnt_l, ql.size());
    chk("empty_f", emp_f, qf.size() == 0);
    chk("empty_l", emp_l, ql.size() == 0);
    chk("full_f", full_f, qf.size() == DEPTH);
    chk("full_l", full_l, ql.size() == DEPTH);
    chk("af_f", af_f, qf.size() >= DEPTH - 1);
    chk("af_l", af_l, ql.size() >= DEPTH - 1);
    chk("ae_f", ae_f, qf.size() <= 1);
    chk("ae_l", ae_l, ql.size() <= 1);
    chk("err_f", err_f, m_err);
    chk("err_l", err_l, m_err);
`ifdef BUFFER_V2_STICKY_ERR_EN
    chk("sticky_f", stk_f, m_stk);
    chk("sticky_l", stk_l, m_stk);
`endif
  end

  task automatic cyc(input bit pe, input bit pu, input bit oe, input bit po, input logic [7:0] d);
    push_en = pe; push = pu; pop_en = oe; pop = po; data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1, 0, 1, 0, 8'h00);
  endtask

  task automatic do_reset();
    push = 0; pop = 0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic fill(input int n);
    for (int i = 1; i <= n; i++) cyc(1, 1, 1, 0, 8'(i));
  endtask

  initial begin
    // Reset state and fill
    do_reset();
    chk("rst_cnt", cnt_f, 0);
    chk("rst_empty", emp_l, 1);
    chk("rst_ae", ae_f, 1);
    chk("rst_af", af_l, 0);
    chk("rst_dout", dout_f, 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 1, 1, 0, 8'(i));
      if (i == 6) chk("af_at6", af_f, 0);
      if (i == 7) chk("af_at7", af_l, 1);
    end
    chk("fill_cnt", cnt_f, 8);
    chk("fill_full", full_l, 1);
    cyc(1, 1, 1, 0, 8'h99);
    chk("ovf_err", err_f, 3'b010);
    chk("ovf_cnt", cnt_l, 8);
    idle();
    chk("ovf_pulse", err_l, 3'b000);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 1, 1, 8'h00);
      chk("pop_f", dout_f, 1 + k);
      chk("pop_l", dout_l, 8 - k);
      chk("pop_vld", vld_f, 1);
      idle();
      chk("pop_vld_off", vld_l, 0);
    end
    chk("pop3_cnt", cnt_f, 5);

    // Full push+pop, then drain through the FIFO wrap point
    do_reset();
    fill(8);
    cyc(1, 1, 1, 1, 8'h09);
    chk("fullpp_f", dout_f, 1);
    chk("fullpp_l", dout_l, 8);
    chk("fullpp_cnt", cnt_f, 8);
    for (int k = 0; k < 8; k++) begin
      cyc(1, 0, 1, 1, 8'h00);
      chk("drain_f", dout_f, k + 2);
      chk("drain_l", dout_l, (k == 0) ? 9 : 8 - k);
    end
    chk("drain_empty", emp_f, 1);

    // Empty-buffer errors
    cyc(1, 0, 1, 1, 8'h00);
    chk("unf_err", err_f, 3'b100);
    chk("unf_vld", vld_l, 0);
    cyc(0, 1, 1, 0, 8'h55);
    chk("dis_err", err_l, 3'b001);
    chk("dis_cnt", cnt_f, 0);
    idle();
`ifdef BUFFER_V2_STICKY_ERR_EN
    chk("sticky_set", stk_f, 3'b101);
    err_clr = 1'b1;
    idle();
    err_clr = 1'b0;
    chk("sticky_clr", stk_l, 3'b000);
`endif

    // LIFO replace with count=3
    do_reset();
    fill(3);
    cyc(1, 1, 1, 1, 8'h0A);
    chk("repl_l", dout_l, 3);
    chk("repl_cnt", cnt_l, 3);
    chk("repl_f", dout_f, 1);
    cyc(1, 0, 1, 1, 8'h00);
    chk("repl_pop_l", dout_l, 8'h0A);
    chk("repl_pop_f", dout_f, 2);

    // Asynchronous reset mid-operation at count=4
    do_reset();
    fill(5);
    cyc(1, 0, 1, 1, 8'h00);
    chk("pre_rst_cnt", cnt_f, 4);
    chk("pre_rst_l", dout_l, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_cnt", cnt_l, 0);
    chk("async_dout", dout_f, 0);
    chk("async_empty", emp_f, 1);
    chk("async_vld", vld_l, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1, 0, 1, 1, 8'h00);
    chk("post_rst_unf", err_f, 3'b100);
    chk("post_rst_dout", dout_l, 0);

    // Randomised traffic, alternating push-heavy and pop-heavy stretches
    for (int c = 0; c < 800; c++) begin
      bit heavy;
      heavy = ((c / 40) % 2) == 0;
      err_clr = ($urandom % 16) == 0;
      cyc(($urandom % 10) != 0,
          heavy ? (($urandom % 4) != 0) : (($urandom % 4) == 0),
          ($urandom % 10) != 0,
          heavy ? (($urandom % 4) == 0) : (($urandom % 4) != 0),
          8'($urandom));
    end
    err_clr = 1'b0;
    idle();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
